fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 176 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Instruction fetch sequencer. A two-state FSM (IDLE/RUN) walks a byte
// program counter (fetch_pc) through a power-of-two instruction memory,
// captures the combinational memory response into a small prefetch FIFO and
// presents the oldest entry to the decode stage. A taken branch flushes the
// FIFO and redirects fetch, costing one bubble cycle.
//
// Optional feature macro: FETCH_PREFETCH_EN
//   defined   -> prefetch FIFO depth 2 (fill_level 0..2)
//   undefined -> prefetch FIFO depth 1 (fill_level 0..1)
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous active-low reset
//   start        : IDLE -> RUN
//   stop         : RUN -> IDLE (wins over start), flushes the FIFO
//   branch_taken : redirect fetch this cycle
//   branch_addr  : byte address of the branch target
//   mem_addr     : byte address to the instruction memory (word aligned)
//   mem_data     : instruction word for mem_addr, same cycle
//   out_valid    : out_instr/out_pc hold a valid entry
//   out_ready    : decode stage accepts the entry
//   out_instr    : fetched instruction (oldest FIFO entry)
//   out_pc       : fetch address of that instruction plus 4 (unwrapped)
//   busy         : 1 while in RUN
//   fill_level   : number of FIFO entries
//   state_dbg    : current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: an entry transfers on a rising edge where out_valid=1 and
// out_ready=1. out_valid never depends on out_ready; out_valid is forced low
// in a cycle with branch_taken=1 because that cycle's contents are flushed.
module fetch_sequencer #(
  parameter int INSTRUCTION_LEN      = 32,
  parameter int INSTRUCTION_MEM_SIZE = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       branch_taken,
  input  logic [INSTRUCTION_LEN-1:0] branch_addr,
  output logic [INSTRUCTION_LEN-1:0] mem_addr,
  input  logic [INSTRUCTION_LEN-1:0] mem_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTRUCTION_LEN-1:0] out_instr,
  output logic [INSTRUCTION_LEN-1:0] out_pc,
  output logic                       busy,
  output logic [1:0]                 fill_level,
  output logic                       state_dbg
);

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int L = INSTRUCTION_LEN;
  localparam logic [L-1:0] PC_STEP     = L'(4);
  localparam logic [L-1:0] MEM_END     = L'(INSTRUCTION_MEM_SIZE);
  localparam logic [L-1:0] ALIGN_MASK  = ~L'(3);
  // Reduce modulo the memory size (power of two) and force word alignment.
  localparam logic [L-1:0] TARGET_MASK = L'(INSTRUCTION_MEM_SIZE - 1) & ALIGN_MASK;
  localparam logic [1:0]   DEPTH_LVL   = 2'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [L-1:0]   fetch_pc_q, fetch_pc_d;
  logic [L-1:0]   pc_inc;
  logic [1:0]     fill_q, fill_d;
  logic [1:0]     wr_idx;
  logic           push, pop, clear;

  // Entry 0 is always the oldest; pops shift the array down.
  logic [L-1:0]   instr_q [DEPTH];
  logic [L-1:0]   pc_q    [DEPTH];
  logic [L-1:0]   instr_d [DEPTH];
  logic [L-1:0]   pc_d    [DEPTH];

  assign pc_inc     = fetch_pc_q + PC_STEP;
  assign mem_addr   = fetch_pc_q & ALIGN_MASK;
  assign out_valid  = (fill_q != 2'd0) && !branch_taken;
  assign out_instr  = instr_q[0];
  assign out_pc     = pc_q[0];
  assign busy       = (state_q == RUN);
  assign fill_level = fill_q;
  assign state_dbg  = state_q;

  // Next state, fetch_pc and push/pop/flush decisions.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    clear      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        // In IDLE a branch only retargets fetch_pc.
        if (branch_taken) fetch_pc_d = branch_addr & TARGET_MASK;
        if (start && !stop) state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          // Leaving RUN: flush, hold fetch_pc. Stop also overrides a branch.
          state_d = IDLE;
          clear   = 1'b1;
        end else if (branch_taken) begin
          // Redirect: flush and drop this cycle's push and pop.
          clear      = 1'b1;
          fetch_pc_d = branch_addr & TARGET_MASK;
        end else begin
          pop  = out_valid && out_ready;
          // A pop in the same cycle frees the slot, so full + pop may push.
          push = (fill_q < DEPTH_LVL) || pop;
          if (push) fetch_pc_d = (pc_inc == MEM_END) ? '0 : pc_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO next-state.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    fill_d  = fill_q;
    // Write slot after any same-cycle pop has shifted the array.
    wr_idx  = fill_q - {1'b0, pop};
    if (clear) begin
      fill_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          instr_d[i] = instr_q[i+1];
          pc_d[i]    = pc_q[i+1];
        end
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_idx == 2'(i)) begin
            instr_d[i] = mem_data;
            pc_d[i]    = pc_inc;
          end
        end
      end
      fill_d = fill_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      fill_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fill_q     <= fill_d;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= instr_d[i];
        pc_q[i]    <= pc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer: a directed vector table, hand
// sequences for stall, async reset and restart, then randomized stimulus
// checked against a queue-based reference model.
module tb_fetch_sequencer;

  localparam int W        = 32;
  localparam int MEM_SIZE = 1024;
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         branch_taken = 1'b0;
  logic [W-1:0] branch_addr = '0;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_instr;
  logic [W-1:0] out_pc;
  logic         busy;
  logic [1:0]   fill_level;
  logic         state_dbg;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .INSTRUCTION_LEN      (W),
    .INSTRUCTION_MEM_SIZE (MEM_SIZE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .busy         (busy),
    .fill_level   (fill_level),
    .state_dbg    (state_dbg)
  );

  // Instruction memory: distinct word per address.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 32'h0001_0003) ^ 32'hA5C3_0F1E;
  endfunction

  assign mem_data = mem_word(mem_addr);

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;

  // Expected FIFO contents, oldest first: {instr, pc_plus_4}.
  logic [2*W-1:0] exp_q[$];
  logic           m_run = 1'b0;
  logic [W-1:0]   m_pc  = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_run = 1'b0;
    m_pc  = '0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic [W-1:0] tgt;
    logic         pop_e;
    logic         push_e;
    logic [2*W-1:0] dropped;
    tgt = (branch_addr % W'(MEM_SIZE)) / 4 * 4;
    if (m_run) begin
      if (stop) begin
        exp_q.delete();
        m_run = 1'b0;
      end else if (branch_taken) begin
        exp_q.delete();
        m_pc = tgt;
      end else begin
        pop_e  = (exp_q.size() != 0) && out_ready;
        push_e = (exp_q.size() < DEPTH) || pop_e;
        if (pop_e) dropped = exp_q.pop_front();
        if (push_e) begin
          exp_q.push_back({mem_word(m_pc), m_pc + 32'd4});
          m_pc = (m_pc + 32'd4) % W'(MEM_SIZE);
        end
      end
    end else begin
      if (branch_taken) m_pc = tgt;
      if (start && !stop) m_run = 1'b1;
    end
  endtask

  task automatic model_check();
    logic [2*W-1:0] head;
    chk("busy", W'(busy), W'(m_run));
    chk("state_dbg", W'(state_dbg), W'(m_run));
    chk("fill_level", W'(fill_level), W'(exp_q.size()));
    chk("mem_addr", mem_addr, m_pc);
    chk("out_valid", W'(out_valid), W'((exp_q.size() != 0) && !branch_taken));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("out_pc", out_pc, head[W-1:0]);
      chk("out_instr", out_instr, head[2*W-1:W]);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive(input logic s, input logic p, input logic b,
                       input logic [W-1:0] ba, input logic r);
    @(negedge clk);
    start        = s;
    stop         = p;
    branch_taken = b;
    branch_addr  = ba;
    out_ready    = r;
    #1;
  endtask

  task automatic step(input logic s, input logic p, input logic b,
                      input logic [W-1:0] ba, input logic r);
    drive(s, p, b, ba, r);
    model_check();
    @(posedge clk);
    model_edge();
  endtask

  // Assert reset away from any clock edge, check outputs cleared at once.
  task automatic do_reset();
    start        = 1'b0;
    stop         = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    out_ready    = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_fill", W'(fill_level), '0);
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_instr", out_instr, '0);
    chk("rst_pc", out_pc, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic         s;
    logic         p;
    logic         b;
    logic [W-1:0] ba;
    logic         r;
    logic         ev;
    logic         eb;
    logic [1:0]   ef;
    logic [W-1:0] ea;
    logic [W-1:0] epc;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int           budget;
    logic [W-1:0] next_pc;

    //              s     p     b     ba         r     ev    eb    ef     ea          epc
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 2'd0, 32'h0,      32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b1, 2'd0, 32'h0,      32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 2'd1, 32'h4,      32'h4};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 2'd1, 32'h8,      32'h8};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 2'd1, 32'hC,      32'hC};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h3C,    1'b1, 1'b0, 1'b1, 2'd1, 32'h10,     32'h0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b1, 2'd0, 32'h3C,     32'h0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 2'd1, 32'h40,     32'h40};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 2'd1, 32'h44,     32'h44};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 2'd0, 32'h44,     32'h0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h3FF,   1'b1, 1'b0, 1'b0, 2'd0, 32'h44,     32'h0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 2'd0, 32'h3FC,    32'h0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b1, 2'd0, 32'h3FC,    32'h0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 2'd1, 32'h0,      32'h400};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 2'd1, 32'h4,      32'h4};

    // Power-on reset.
    #2;
    do_reset();

    // Directed table: straight-line fetch, branch bubble, stop+start,
    // IDLE branch, wrap at the top of memory.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].s, tbl[i].p, tbl[i].b, tbl[i].ba, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), W'(out_valid), W'(tbl[i].ev));
      chk($sformatf("tbl%0d_busy", i), W'(busy), W'(tbl[i].eb));
      chk($sformatf("tbl%0d_fill", i), W'(fill_level), W'(tbl[i].ef));
      chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].ea);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_instr", i), out_instr, mem_word(tbl[i].epc - 32'd4));
      end
      @(posedge clk);
      model_edge();
    end

    // Stall: out_ready low for 5 cycles after start, then drain in order.
    do_reset();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("stall_addr", mem_addr, W'(4 * DEPTH));
    chk("stall_fill", W'(fill_level), W'(DEPTH));
    model_check();
    next_pc = 32'd4;
    if (out_valid) begin
      chk("drain_pc", out_pc, next_pc);
      next_pc += 32'd4;
    end
    @(posedge clk);
    model_edge();
    budget = 20;
    while (next_pc != 32'd20 && budget > 0) begin
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
      model_check();
      if (out_valid) begin
        chk("drain_pc", out_pc, next_pc);
        next_pc += 32'd4;
      end
      @(posedge clk);
      model_edge();
      budget--;
    end
    if (budget == 0) chk("drain_timeout", next_pc, 32'd20);

    // Async reset mid-RUN with a full buffer, then restart from address 0.
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("prereset_fill", W'(fill_level), W'(DEPTH));
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("restart_valid", W'(out_valid), 32'd1);
    chk("restart_pc", out_pc, 32'd4);
    model_check();
    @(posedge clk);
    model_edge();

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) == 0, W'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
